timer_scheduler: RTL and testbench

- Multi-channel periodic interrupt scheduler for the Position/Timer subsystem.
- Shares one internal free-running cycle counter among NUM_CH requesters.
- Each channel is programmed with a period. When the counter reaches the channel's deadline, the block raises that channel's pending interrupt and reloads the deadline.
- A round-robin selector presents one pending channel at a time to the consumer. Replaces per-requester counter/comparator pairs.

---
 rtl/timer_scheduler_if.sv | 26 ++
 rtl/timer_scheduler.sv | 62 ++++++
 tb/tb_timer_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if: control/status bundle between a timer consumer and the scheduler
interface timer_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 32,
  parameter int ID_W = 2
);
  logic run;
  logic [NUM_CH-1:0] ch_en;
  logic load;
  logic [ID_W-1:0] load_ch;
  logic [WIDTH-1:0] load_period;
  logic [NUM_CH-1:0] int_ack;
  logic [WIDTH-1:0] count;
  logic [NUM_CH-1:0] int_pend;
  logic [NUM_CH-1:0] overrun;
  logic irq;
  logic [ID_W-1:0] irq_id;
  modport master (
    output run, ch_en, load, load_ch, load_period, int_ack,
    input count, int_pend, overrun, irq, irq_id
  );
  modport slave (
    input run, ch_en, load, load_ch, load_period, int_ack,
    output count, int_pend, overrun, irq, irq_id
  );
endinterface

// File: rtl/timer_scheduler.sv
// timer_scheduler: shared free-running counter driving NUM_CH periodic interrupt channels
module timer_scheduler #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 32,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic rst,
  timer_scheduler_if.slave bus
);
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] period [NUM_CH];
  logic [WIDTH-1:0] deadline [NUM_CH];
  logic [NUM_CH-1:0] pend, ovr, fire, ld;
  logic [ID_W-1:0] rr_ptr, sel;
  logic irq;
  always_comb begin
    fire = '0;
    ld = '0;
    sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i] = bus.run & bus.ch_en[i] & (period[i] != '0) & (count == deadline[i]);
      ld[i] = bus.load & (bus.load_ch == ID_W'(i));
    end
    // walk backwards so the channel closest to rr_ptr is the last one written
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (pend[(int'(rr_ptr) + k) % NUM_CH]) sel = ID_W'((int'(rr_ptr) + k) % NUM_CH);
  end
  assign irq = |pend;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      pend <= '0;
      ovr <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= '0;
        deadline[i] <= '0;
      end
    end else begin
      if (bus.run) count <= count + 1'b1;
      if (irq && bus.int_ack[sel]) rr_ptr <= (sel == ID_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ld[i]) begin
          period[i] <= bus.load_period;
          deadline[i] <= count + bus.load_period;
          pend[i] <= 1'b0;
          ovr[i] <= 1'b0;
        end else begin
          if (fire[i]) deadline[i] <= deadline[i] + period[i];
          pend[i] <= fire[i] | (pend[i] & ~bus.int_ack[i]);
          ovr[i] <= (fire[i] & pend[i] & ~bus.int_ack[i]) | (ovr[i] & ~bus.int_ack[i]);
        end
      end
    end
  end
  assign bus.count = count;
  assign bus.int_pend = pend;
  assign bus.overrun = ovr;
  assign bus.irq = irq;
  assign bus.irq_id = irq ? sel : '0;
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed checks of timer_scheduler; 8-bit counter so wrap is reachable
module tb_timer_scheduler;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  timer_scheduler_if #(.NUM_CH(4), .WIDTH(8), .ID_W(2)) b ();
  timer_scheduler #(.NUM_CH(4), .WIDTH(8), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask
  task automatic do_load(input int ch, input int p);
    b.load = 1'b1;
    b.load_ch = 2'(ch);
    b.load_period = 8'(p);
    tick(1);
    b.load = 1'b0;
  endtask
  task automatic do_ack(input logic [3:0] m);
    b.int_ack = m;
    tick(1);
    b.int_ack = '0;
  endtask
  initial begin
    rst = 1'b1;
    b.run = 1'b0;
    b.ch_en = 4'hF;
    b.load = 1'b0;
    b.load_ch = '0;
    b.load_period = '0;
    b.int_ack = '0;
    tick(2);
    rst = 1'b0;
    b.run = 1'b1;
    check("rst_count", b.count, 0);
    check("rst_pend", b.int_pend, 0);
    check("rst_ovr", b.overrun, 0);
    check("rst_irq", b.irq, 0);
    check("rst_id", b.irq_id, 0);
    // basic period: load at count 5, fires after 15 and 25
    tick(5);
    do_load(0, 10);
    tick(9);
    check("p0_before", b.int_pend, 0);
    tick(1);
    check("p0_count", b.count, 16);
    check("p0_pend", b.int_pend, 4'b0001);
    check("p0_irq", b.irq, 1);
    check("p0_id", b.irq_id, 0);
    do_ack(4'b0001);
    check("p0_acked", b.int_pend, 0);
    tick(8);
    check("p0_gap", b.int_pend, 0);
    tick(1);
    check("p0_again", b.int_pend, 4'b0001);
    // latency and immediate ack
    do_reset();
    do_load(1, 4);
    tick(3);
    check("p1_early", b.int_pend, 0);
    tick(1);
    check("p1_fire1", b.int_pend, 4'b0010);
    do_ack(4'b0010);
    check("p1_ack1", b.int_pend, 0);
    tick(2);
    check("p1_gap", b.int_pend, 0);
    tick(1);
    check("p1_fire2", b.int_pend, 4'b0010);
    check("p1_ovr", b.overrun, 0);
    do_ack(4'b0010);
    check("p1_ack2", b.int_pend, 0);
    check("p1_ovr2", b.overrun, 0);
    // overrun then ack coinciding with a fire
    do_reset();
    do_load(2, 3);
    tick(3);
    check("p2_fire1", b.int_pend, 4'b0100);
    check("p2_noovr", b.overrun, 0);
    tick(3);
    check("p2_ovr", b.overrun, 4'b0100);
    tick(2);
    do_ack(4'b0100);
    check("p2_simul_pend", b.int_pend, 4'b0100);
    check("p2_simul_ovr", b.overrun, 0);
    check("p2_id", b.irq_id, 2);
    // round robin
    do_reset();
    do_load(0, 5);
    do_load(3, 4);
    tick(4);
    check("rr_both", b.int_pend, 4'b1001);
    check("rr_id0", b.irq_id, 0);
    do_ack(4'b0001);
    check("rr_after0", b.int_pend, 4'b1000);
    check("rr_id3", b.irq_id, 3);
    tick(4);
    check("rr_refire", b.int_pend, 4'b1001);
    check("rr_stay3", b.irq_id, 3);
    check("rr_ovr3", b.overrun, 4'b1000);
    do_ack(4'b1000);
    check("rr_after3", b.int_pend, 4'b0001);
    check("rr_back0", b.irq_id, 0);
    check("rr_ovrclr", b.overrun, 0);
    // wrap, idle channel and run gating
    do_reset();
    tick(252);
    check("wr_pre", b.count, 8'hFC);
    do_load(1, 8);
    tick(7);
    check("wr_early", b.int_pend, 0);
    tick(1);
    check("wr_count", b.count, 5);
    check("wr_fire", b.int_pend, 4'b0010);
    do_load(1, 0);
    check("idle_clr", b.int_pend, 0);
    tick(20);
    check("idle_quiet", b.int_pend, 0);
    do_load(2, 2);
    tick(1);
    b.run = 1'b0;
    tick(3);
    check("hold_count", b.count, 28);
    check("hold_nofire", b.int_pend, 0);
    b.run = 1'b1;
    tick(1);
    check("resume_fire", b.int_pend, 4'b0100);
    // reset mid-operation
    do_reset();
    do_load(0, 2);
    do_load(2, 1);
    tick(2);
    check("mid_pend", b.int_pend, 4'b0101);
    check("mid_ovr", b.overrun, 4'b0100);
    do_reset();
    check("mid_count", b.count, 0);
    check("mid_pend0", b.int_pend, 0);
    check("mid_ovr0", b.overrun, 0);
    check("mid_irq0", b.irq, 0);
    check("mid_id0", b.irq_id, 0);
    tick(10);
    check("mid_quiet", b.int_pend, 0);
    check("mid_count10", b.count, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
